dither_sched: RTL and testbench

- Sequences the 6-bit to 3-bit colour dither stage between rbzero and the VGA pins.
- Generates the dither `field` per frame for temporal dithering, with a programmable frame divisor.
- Accepts mode/divisor configuration through a valid/ready handshake and applies it only at frame boundaries.
- Registers RGB and sync outputs, forcing black outside the visible area.

---
 rtl/dither_pkg.sv | 31 +++
 rtl/dither_field_seq.sv | 98 +++++++++
 rtl/dither_sched.sv | 77 +++++++
 tb/tb_dither_sched.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dither_pkg.sv
// Shared constants and the per-channel dither cell for the 6-bit to 3-bit colour stage.
package dither_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_THRESH   = 2'd0;
  localparam mode_t MODE_STATIC   = 2'd1;
  localparam mode_t MODE_TEMPORAL = 2'd2;
  localparam mode_t MODE_FREEZE   = 2'd3;

  localparam mode_t RESET_MODE = MODE_STATIC;

  localparam int unsigned CFG_MODE_LSB = 0;
  localparam int unsigned CFG_MODE_MSB = 1;
  localparam int unsigned CFG_DIV_LSB  = 2;
  localparam int unsigned CFG_DIV_MSB  = 3;

  // Ordered 2x2 dither: level 2 lights a checkerboard, level 1 one pixel of four.
  function automatic logic dither_bit(input logic [1:0] lvl, input logic xo, input logic yo,
                                      input logic fld);
    logic res;
    unique case (lvl)
      2'd3:    res = 1'b1;
      2'd2:    res = xo ^ yo ^ fld;
      2'd1:    res = (xo ^ fld) & (yo ^ fld);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dither_field_seq.sv
// Per-frame dither field sequencer: vsync edge detect, config handshake and
// frame-boundary application of mode/divisor.
module dither_field_seq
  import dither_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       vsync_ni,
  input  logic       cfg_valid_i,
  input  logic [3:0] cfg_data_i,
  output logic       cfg_ready_o,
  output logic       field_o,
  output mode_t      mode_o,
  output logic       frame_start_o
);

  logic       vsync_q;
  logic       pending_q, pending_d;
  logic [3:0] pend_cfg_q, pend_cfg_d;
  mode_t      mode_q, mode_d;
  logic [1:0] div_q, div_d;
  logic [1:0] cnt_q, cnt_d;
  logic       field_q, field_d;
  logic       frame_start_q;
  logic       fe;
  logic       xfer;

  assign fe   = vsync_q & ~vsync_ni;
  assign xfer = cfg_valid_i & ~pending_q;

  always_comb begin
    field_d    = field_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    div_d      = div_q;
    pending_d  = pending_q;
    pend_cfg_d = pend_cfg_q;

    // A config captured on an edge cycle is only applied at the following edge.
    if (xfer) begin
      pending_d  = 1'b1;
      pend_cfg_d = cfg_data_i;
    end

    if (fe) begin
      case (mode_q)
        MODE_THRESH, MODE_STATIC: begin
          field_d = 1'b0;
          cnt_d   = 2'd0;
        end
        MODE_TEMPORAL: begin
          if (cnt_q == div_q) begin
            cnt_d   = 2'd0;
            field_d = ~field_q;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        default: ;
      endcase

      if (pending_q) begin
        mode_d    = pend_cfg_q[CFG_MODE_MSB:CFG_MODE_LSB];
        div_d     = pend_cfg_q[CFG_DIV_MSB:CFG_DIV_LSB];
        cnt_d     = 2'd0;
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      vsync_q       <= 1'b1;
      pending_q     <= 1'b0;
      pend_cfg_q    <= 4'd0;
      mode_q        <= RESET_MODE;
      div_q         <= 2'd0;
      cnt_q         <= 2'd0;
      field_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      vsync_q       <= vsync_ni;
      pending_q     <= pending_d;
      pend_cfg_q    <= pend_cfg_d;
      mode_q        <= mode_d;
      div_q         <= div_d;
      cnt_q         <= cnt_d;
      field_q       <= field_d;
      frame_start_q <= fe;
    end
  end

  assign cfg_ready_o   = ~pending_q;
  assign field_o       = field_q;
  assign mode_o        = mode_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: rtl/dither_sched.sv
// Colour dither stage between rbzero and the VGA pins: 6-bit BBGGRR in, registered
// 3-bit BGR out with syncs delayed to stay aligned.
module dither_sched
  import dither_pkg::*;
#(
  parameter int unsigned H_VIS = 640,
  parameter int unsigned V_VIS = 480
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hsync_n,
  input  logic       vsync_n,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic [5:0] rgb6,
  input  logic       cfg_valid,
  input  logic [3:0] cfg_data,
  output logic       cfg_ready,
  output logic       hsync_n_o,
  output logic       vsync_n_o,
  output logic [2:0] rgb3,
  output logic       field,
  output logic       frame_start,
  output logic [1:0] mode
);

  mode_t      mode_w;
  logic       field_w;
  logic       blank;
  logic [2:0] pix;
  logic [2:0] rgb_q;
  logic       hs_q, vs_q;

  dither_field_seq u_seq (
    .clk_i         (clk),
    .reset_ni      (reset_n),
    .vsync_ni      (vsync_n),
    .cfg_valid_i   (cfg_valid),
    .cfg_data_i    (cfg_data),
    .cfg_ready_o   (cfg_ready),
    .field_o       (field_w),
    .mode_o        (mode_w),
    .frame_start_o (frame_start)
  );

  assign blank = (hpos >= 10'(H_VIS)) | (vpos >= 10'(V_VIS));

  always_comb begin
    pix = 3'b000;
    for (int k = 0; k < 3; k++) begin
      if (mode_w == MODE_THRESH) begin
        pix[k] = rgb6[2*k+1];
      end else begin
        pix[k] = dither_bit(rgb6[2*k +: 2], hpos[0], vpos[0], field_w);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rgb_q <= 3'b000;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      rgb_q <= blank ? 3'b000 : pix;
      hs_q  <= hsync_n;
      vs_q  <= vsync_n;
    end
  end

  assign rgb3      = rgb_q;
  assign hsync_n_o = hs_q;
  assign vsync_n_o = vs_q;
  assign field     = field_w;
  assign mode      = mode_w;

endmodule

// File: tb/tb_dither_sched.sv
// Scoreboard bench for dither_sched: the driver queues hand-computed expectations,
// a monitor pops and compares one entry per driven cycle.
module tb_dither_sched;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       hsync_n = 1'b1;
  logic       vsync_n = 1'b1;
  logic [9:0] hpos = '0;
  logic [9:0] vpos = '0;
  logic [5:0] rgb6 = '0;
  logic       cfg_valid = 1'b0;
  logic [3:0] cfg_data = '0;
  logic       cfg_ready, hsync_n_o, vsync_n_o, field, frame_start;
  logic [2:0] rgb3;
  logic [1:0] mode;
  logic       pix_vld = 1'b0;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [2:0] rgb;
    logic       fld;
    logic [1:0] md;
    logic       rdy;
    logic       fs;
    logic       hs;
    logic       vs;
    string      nm;
  } exp_t;

  exp_t q[$];

  dither_sched dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .hpos        (hpos),
    .vpos        (vpos),
    .rgb6        (rgb6),
    .cfg_valid   (cfg_valid),
    .cfg_data    (cfg_data),
    .cfg_ready   (cfg_ready),
    .hsync_n_o   (hsync_n_o),
    .vsync_n_o   (vsync_n_o),
    .rgb3        (rgb3),
    .field       (field),
    .frame_start (frame_start),
    .mode        (mode)
  );

  always #20 clk = ~clk;

  task automatic chk(input string nm, input string sig, input logic [2:0] act,
                     input logic [2:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s.%s got=%b want=%b", nm, sig, act, want);
    end
  endtask

  // One driven cycle; expectations describe DUT state just after the next posedge.
  task automatic d(input logic rn, input int h, input int v, input logic [5:0] c,
                   input logic vs, input logic cv, input logic [3:0] cd,
                   input logic [2:0] er, input logic ef, input logic [1:0] em,
                   input logic erdy, input logic efs, input string nm);
    exp_t e;
    @(negedge clk);
    reset_n   = rn;
    hpos      = 10'(h);
    vpos      = 10'(v);
    rgb6      = c;
    vsync_n   = vs;
    hsync_n   = ~(hpos[0] & vpos[0]);
    cfg_valid = cv;
    cfg_data  = cd;
    pix_vld   = 1'b1;
    e.rgb = er; e.fld = ef; e.md = em; e.rdy = erdy; e.fs = efs;
    e.hs  = hsync_n; e.vs = vs; e.nm = nm;
    q.push_back(e);
  endtask

  initial begin : monitor
    logic v;
    exp_t e;
    forever begin
      @(posedge clk);
      v = pix_vld;
      #1;
      if (v) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL underflow got=empty want=entry");
        end else begin
          e = q.pop_front();
          chk(e.nm, "rgb3", rgb3, e.rgb);
          chk(e.nm, "field", {2'b0, field}, {2'b0, e.fld});
          chk(e.nm, "mode", {1'b0, mode}, {1'b0, e.md});
          chk(e.nm, "cfg_ready", {2'b0, cfg_ready}, {2'b0, e.rdy});
          chk(e.nm, "frame_start", {2'b0, frame_start}, {2'b0, e.fs});
          chk(e.nm, "hsync", {2'b0, hsync_n_o}, {2'b0, e.hs});
          chk(e.nm, "vsync", {2'b0, vsync_n_o}, {2'b0, e.vs});
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // reset, with a config request that must be ignored
    d(0, 10, 10, 6'h3F, 1, 1, 4'b0000, 3'b000, 0, 1, 1, 0, "rst_a");
    d(0, 10, 10, 6'h3F, 1, 0, 4'b0000, 3'b000, 0, 1, 1, 0, "rst_b");
    d(1, 10, 10, 6'h3F, 1, 0, 4'b0000, 3'b111, 0, 1, 1, 0, "white");
    // static dither, level 2 and level 1
    d(1, 0, 0, 6'h2A, 1, 0, 0, 3'b000, 0, 1, 1, 0, "st_hi00");
    d(1, 1, 0, 6'h2A, 1, 0, 0, 3'b111, 0, 1, 1, 0, "st_hi10");
    d(1, 0, 1, 6'h2A, 1, 0, 0, 3'b111, 0, 1, 1, 0, "st_hi01");
    d(1, 1, 1, 6'h2A, 1, 0, 0, 3'b000, 0, 1, 1, 0, "st_hi11");
    d(1, 0, 0, 6'h15, 1, 0, 0, 3'b000, 0, 1, 1, 0, "st_lo00");
    d(1, 1, 0, 6'h15, 1, 0, 0, 3'b000, 0, 1, 1, 0, "st_lo10");
    d(1, 0, 1, 6'h15, 1, 0, 0, 3'b000, 0, 1, 1, 0, "st_lo01");
    d(1, 1, 1, 6'h15, 1, 0, 0, 3'b111, 0, 1, 1, 0, "st_lo11");
    // blanking boundaries
    d(1, 640, 10, 6'h3F, 1, 0, 0, 3'b000, 0, 1, 1, 0, "blank_h");
    d(1, 10, 480, 6'h3F, 1, 0, 0, 3'b000, 0, 1, 1, 0, "blank_v");
    d(1, 639, 479, 6'h3F, 1, 0, 0, 3'b111, 0, 1, 1, 0, "last_vis");
    // frame edge in static mode
    d(1, 10, 10, 6'h2A, 0, 0, 0, 3'b000, 0, 1, 1, 1, "fe_static");
    d(1, 10, 10, 6'h2A, 1, 0, 0, 3'b000, 0, 1, 1, 0, "post_fe");
    // temporal div=1, then a rejected request while pending
    d(1, 0, 0, 6'h2A, 1, 1, 4'b0110, 3'b000, 0, 1, 0, 0, "cfg_acc");
    d(1, 0, 0, 6'h2A, 1, 1, 4'b0011, 3'b000, 0, 1, 0, 0, "cfg_busy");
    d(1, 1, 0, 6'h2A, 0, 0, 0, 3'b111, 0, 2, 1, 1, "apply_tmp");
    d(1, 1, 0, 6'h2A, 1, 0, 0, 3'b111, 0, 2, 1, 0, "tmp_f1");
    d(1, 1, 0, 6'h2A, 0, 0, 0, 3'b111, 0, 2, 1, 1, "tmp_e2");
    d(1, 1, 0, 6'h2A, 1, 0, 0, 3'b111, 0, 2, 1, 0, "tmp_f2");
    d(1, 1, 0, 6'h2A, 0, 0, 0, 3'b111, 1, 2, 1, 1, "tmp_e3");
    d(1, 1, 0, 6'h2A, 1, 0, 0, 3'b000, 1, 2, 1, 0, "tmp_f3");
    d(1, 1, 0, 6'h2A, 0, 0, 0, 3'b000, 1, 2, 1, 1, "tmp_e4");
    d(1, 1, 0, 6'h2A, 1, 0, 0, 3'b000, 1, 2, 1, 0, "tmp_f4");
    d(1, 1, 0, 6'h2A, 0, 0, 0, 3'b000, 0, 2, 1, 1, "tmp_e5");
    d(1, 1, 0, 6'h2A, 1, 0, 0, 3'b111, 0, 2, 1, 0, "tmp_f5");
    // request on the same cycle as the edge: applied one edge later
    d(1, 1, 0, 6'h2A, 0, 1, 4'b0011, 3'b111, 0, 2, 0, 1, "fe_and_cfg");
    d(1, 1, 0, 6'h2A, 1, 0, 0, 3'b111, 0, 2, 0, 0, "fc_hold");
    d(1, 1, 0, 6'h2A, 0, 0, 0, 3'b111, 1, 3, 1, 1, "apply_frz");
    d(1, 1, 0, 6'h2A, 1, 0, 0, 3'b000, 1, 3, 1, 0, "frz_f0");
    for (int i = 0; i < 5; i++) begin
      d(1, 1, 0, 6'h2A, 0, 0, 0, 3'b000, 1, 3, 1, 1, "frz_e");
      d(1, 1, 0, 6'h2A, 1, 0, 0, 3'b000, 1, 3, 1, 0, "frz_f");
    end
    // reset while a config is pending
    d(1, 1, 0, 6'h2A, 1, 1, 4'b0000, 3'b000, 1, 3, 0, 0, "cfg_thr");
    d(0, 1, 0, 6'h2A, 1, 0, 0, 3'b000, 0, 1, 1, 0, "rst_mid");
    d(1, 0, 1, 6'h2A, 0, 0, 0, 3'b111, 0, 1, 1, 1, "fe_after_rst");
    d(1, 0, 1, 6'h2A, 1, 0, 0, 3'b111, 0, 1, 1, 0, "post_rst");
    // threshold mode
    d(1, 0, 0, 6'h3F, 1, 1, 4'b0000, 3'b111, 0, 1, 0, 0, "cfg_thr2");
    d(1, 0, 0, 6'h3F, 0, 0, 0, 3'b111, 0, 0, 1, 1, "apply_thr");
    d(1, 0, 0, 6'h26, 1, 0, 0, 3'b101, 0, 0, 1, 0, "thr_00");
    d(1, 1, 1, 6'h26, 1, 0, 0, 3'b101, 0, 0, 1, 0, "thr_11");
    d(1, 5, 3, 6'h26, 1, 0, 0, 3'b101, 0, 0, 1, 0, "thr_53");
    d(1, 0, 0, 6'h2A, 1, 0, 0, 3'b111, 0, 0, 1, 0, "thr_2a");
    d(1, 640, 0, 6'h3F, 1, 0, 0, 3'b000, 0, 0, 1, 0, "thr_blank");
    @(negedge clk);
    pix_vld = 1'b0;
    repeat (5) begin
      if (q.size() != 0) @(negedge clk);
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
